pc_status_unit: RTL and testbench

//  Program-flow/status stage directly downstream of the ALU. Owns the 20-bit program pointer
//  and the 4-bit status register {mode,carry,sign,zero}. Consumes ALU flags and the decoded

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/pc_status_unit_status_reg.sv | 39 +++
 rtl/pc_status_unit.sv | 118 +++++++++++
 tb/tb_pc_status_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the program-flow/status stage: widths, flow opcodes,
// status bit positions, FSM states and the jump-condition helper.
package cpu_pkg;

  localparam int PC_W     = 20;
  localparam int STATUS_W = 4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_JMP   = 4'd1;
  localparam logic [3:0] OP_JMPZ  = 4'd2;
  localparam logic [3:0] OP_JMPS  = 4'd3;
  localparam logic [3:0] OP_JMPZS = 4'd4;
  localparam logic [3:0] OP_LDSR  = 4'd5;
  localparam logic [3:0] OP_XORSR = 4'd6;
  localparam logic [3:0] OP_TRAP  = 4'd7;
  localparam logic [3:0] OP_ALU   = 4'd8;

  localparam int SR_ZERO  = 0;
  localparam int SR_SIGN  = 1;
  localparam int SR_CARRY = 2;
  localparam int SR_MODE  = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  // Conditions look only at the committed status, never at the in-flight ALU flags.
  function automatic logic jump_taken(input logic [3:0] op, input logic [STATUS_W-1:0] sr);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JMP:   taken = 1'b1;
      OP_JMPZ:  taken = sr[SR_ZERO];
      OP_JMPS:  taken = sr[SR_SIGN];
      OP_JMPZS: taken = sr[SR_ZERO] & sr[SR_SIGN];
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_status_unit_status_reg.sv
// Status register {mode,carry,sign,zero}: full write, xor-write, or ALU flag
// commit (mode preserved). Callers assert at most one enable per cycle.
module status_reg
  import cpu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic                xor_en_i,
  input  logic                flag_en_i,
  input  logic [STATUS_W-1:0] data_i,
  input  logic [2:0]          flags_i,   // {carry,sign,zero}
  output logic [STATUS_W-1:0] status_o
);

  logic [STATUS_W-1:0] status_q, status_d;

  always_comb begin
    status_d = status_q;
    if (wr_en_i) begin
      status_d = data_i;
    end else if (xor_en_i) begin
      status_d = status_q ^ data_i;
    end else if (flag_en_i) begin
      status_d = {status_q[SR_MODE], flags_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o = status_q;

endmodule

// File: rtl/pc_status_unit.sv
// Program-flow/status stage: program pointer, status register, jump/trap FSM.
// Ops take effect on the accepting edge; ops are refused outside RUN.
module pc_status_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = PC_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 20'hFFFF0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                op_valid_i,
  output logic                op_ready_o,
  input  logic [3:0]          op_code_i,
  input  logic [ADDR_W-1:0]   jmp_addr_i,
  input  logic [STATUS_W-1:0] sr_data_i,
  input  logic                alu_zero_i,
  input  logic                alu_sign_i,
  input  logic                alu_carry_i,
  input  logic                flag_we_i,
  input  logic                trap_ack_i,
  output logic [ADDR_W-1:0]   prog_point_o,
  output logic [STATUS_W-1:0] status_o,
  output logic                mode_o,
  output logic                flush_o,
  output logic                trapped_o,
  output logic [ADDR_W-1:0]   epc_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              fire;
  logic              sr_wr, sr_xor, sr_flag;
  logic [STATUS_W-1:0] status;

  assign op_ready_o = (state_q == ST_RUN);
  assign fire       = op_valid_i & op_ready_o;
  assign pc_inc     = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    sr_wr   = 1'b0;
    sr_xor  = 1'b0;
    sr_flag = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (fire) begin
          case (op_code_i)
            OP_NOP: pc_d = pc_inc;
            OP_JMP, OP_JMPZ, OP_JMPS, OP_JMPZS: begin
              if (jump_taken(op_code_i, status)) begin
                pc_d    = jmp_addr_i;
                state_d = ST_FLUSH;
              end else begin
                pc_d = pc_inc;
              end
            end
            OP_LDSR: begin
              pc_d  = pc_inc;
              sr_wr = 1'b1;
            end
            OP_XORSR: begin
              pc_d   = pc_inc;
              sr_xor = 1'b1;
            end
            OP_ALU: begin
              pc_d    = pc_inc;
              sr_flag = flag_we_i;
            end
            default: begin  // OP_TRAP and every undefined opcode
              epc_d   = pc_inc;
              pc_d    = TRAP_VEC;
              state_d = ST_TRAP;
            end
          endcase
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_TRAP:  if (trap_ack_i) state_d = ST_FLUSH;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  status_reg u_status_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (sr_wr),
    .xor_en_i  (sr_xor),
    .flag_en_i (sr_flag),
    .data_i    (sr_data_i),
    .flags_i   ({alu_carry_i, alu_sign_i, alu_zero_i}),
    .status_o  (status)
  );

  assign status_o     = status;
  assign mode_o       = status[SR_MODE];
  assign prog_point_o = pc_q;
  assign epc_o        = epc_q;
  assign flush_o      = (state_q == ST_FLUSH);
  assign trapped_o    = (state_q == ST_TRAP);

endmodule

// File: tb/tb_pc_status_unit.sv
// Directed-vector bench for pc_status_unit with hand-computed expectations.
module tb_pc_status_unit;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [3:0]  op_code_i;
  logic [19:0] jmp_addr_i;
  logic [3:0]  sr_data_i;
  logic        alu_zero_i, alu_sign_i, alu_carry_i, flag_we_i, trap_ack_i;
  logic [19:0] prog_point_o;
  logic [3:0]  status_o;
  logic        mode_o, flush_o, trapped_o;
  logic [19:0] epc_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pc_status_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .op_valid_i   (op_valid_i),
    .op_ready_o   (op_ready_o),
    .op_code_i    (op_code_i),
    .jmp_addr_i   (jmp_addr_i),
    .sr_data_i    (sr_data_i),
    .alu_zero_i   (alu_zero_i),
    .alu_sign_i   (alu_sign_i),
    .alu_carry_i  (alu_carry_i),
    .flag_we_i    (flag_we_i),
    .trap_ack_i   (trap_ack_i),
    .prog_point_o (prog_point_o),
    .status_o     (status_o),
    .mode_o       (mode_o),
    .flush_o      (flush_o),
    .trapped_o    (trapped_o),
    .epc_o        (epc_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then settle past the edge.
  task automatic cyc(input logic v, input logic [3:0] code, input logic [19:0] addr,
                     input logic [3:0] sr, input logic z, input logic s, input logic c,
                     input logic fwe, input logic ack);
    op_valid_i = v;   op_code_i  = code; jmp_addr_i = addr; sr_data_i = sr;
    alu_zero_i = z;   alu_sign_i = s;    alu_carry_i = c;   flag_we_i = fwe;
    trap_ack_i = ack;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, OP_NOP, 20'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic op(input logic [3:0] code, input logic [19:0] addr);
    cyc(1'b1, code, addr, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    idle();
    check("rst_pc", prog_point_o, 20'h0);
    check("rst_status", status_o, 4'h0);
    check("rst_ready", op_ready_o, 1'b1);
    check("rst_flush", flush_o, 1'b0);
    check("rst_trapped", trapped_o, 1'b0);
    check("rst_epc", epc_o, 20'h0);
    rst_i = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      op(OP_NOP, 20'h0);
      check("nop_pc", prog_point_o, 20'(i));
      check("nop_status", status_o, 4'h0);
      check("nop_flush", flush_o, 1'b0);
    end

    cyc(1'b1, OP_ALU, 20'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("alu1_pc", prog_point_o, 20'h4);
    check("alu1_status", status_o, 4'b0011);
    op(OP_JMPZS, 20'h00100);
    check("jzs_pc", prog_point_o, 20'h00100);
    check("jzs_flush", flush_o, 1'b1);
    check("jzs_ready", op_ready_o, 1'b0);
    op(OP_NOP, 20'h0);  // offered during FLUSH: must be ignored
    check("flush_ign_pc", prog_point_o, 20'h00100);
    check("flush_end", flush_o, 1'b0);
    check("flush_ready", op_ready_o, 1'b1);

    cyc(1'b1, OP_ALU, 20'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("alu2_status", status_o, 4'b0110);
    op(OP_JMPZ, 20'h00200);
    check("jz_nt_pc", prog_point_o, 20'h00102);
    check("jz_nt_flush", flush_o, 1'b0);
    cyc(1'b1, OP_ALU, 20'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    op(OP_JMPZ, 20'h00200);
    check("jz_t_pc", prog_point_o, 20'h00200);
    check("jz_t_flush", flush_o, 1'b1);
    idle();
    op(OP_JMP, 20'h00200);
    check("jself_pc", prog_point_o, 20'h00200);
    check("jself_flush", flush_o, 1'b1);
    idle();

    cyc(1'b1, OP_LDSR, 20'h0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ldsr_status", status_o, 4'b1010);
    check("ldsr_mode", mode_o, 1'b1);
    check("ldsr_pc", prog_point_o, 20'h00201);
    cyc(1'b1, OP_XORSR, 20'h0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("xorsr_status", status_o, 4'b0101);
    check("xorsr_mode", mode_o, 1'b0);
    cyc(1'b1, OP_ALU, 20'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("alu_nowe_status", status_o, 4'b0101);
    check("alu_nowe_pc", prog_point_o, 20'h00203);
    cyc(1'b1, OP_LDSR, 20'h0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_ALU, 20'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("alu_keep_mode", status_o, 4'b1001);

    op(OP_JMP, 20'h00050);
    idle();
    op(4'hC, 20'h0);
    check("trap_epc", epc_o, 20'h00051);
    check("trap_pc", prog_point_o, 20'hFFFF0);
    check("trap_trapped", trapped_o, 1'b1);
    check("trap_ready", op_ready_o, 1'b0);
    check("trap_status", status_o, 4'b1001);
    for (int i = 0; i < 5; i++) begin
      op(OP_JMP, 20'h12345);
      check("trap_ign_pc", prog_point_o, 20'hFFFF0);
      check("trap_hold", trapped_o, 1'b1);
    end
    cyc(1'b0, OP_NOP, 20'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ack_flush", flush_o, 1'b1);
    check("ack_trapped", trapped_o, 1'b0);
    check("ack_ready", op_ready_o, 1'b0);
    idle();
    check("ack_run_ready", op_ready_o, 1'b1);
    check("ack_run_flush", flush_o, 1'b0);

    op(OP_JMP, 20'hFFFFF);
    idle();
    cyc(1'b1, OP_NOP, 20'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // ack in RUN is ignored
    check("wrap_pc", prog_point_o, 20'h00000);
    check("wrap_status", status_o, 4'b1001);
    check("wrap_flush", flush_o, 1'b0);

    op(OP_TRAP, 20'h0);
    check("optrap_epc", epc_o, 20'h00001);
    check("optrap_trapped", trapped_o, 1'b1);
    rst_i = 1'b1;
    op(OP_NOP, 20'h0);
    rst_i = 1'b0;
    check("rst_trap_pc", prog_point_o, 20'h0);
    check("rst_trap_trapped", trapped_o, 1'b0);
    check("rst_trap_epc", epc_o, 20'h0);
    check("rst_trap_status", status_o, 4'h0);
    check("rst_trap_ready", op_ready_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
